serial_add_sub: RTL and testbench

//   Multi-cycle, digit-serial two's-complement adder/subtractor built from ripple full-adder cells.

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/full_adder.sv | 14 +
 rtl/ripple_digit.sv | 31 +++
 rtl/serial_add_sub.sv | 115 +++++++++++
 tb/tb_serial_add_sub.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic units: FSM encoding and digit count.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell.
// Combinational, no backpressure.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/ripple_digit.sv
// DIGIT-bit ripple-carry adder built from full-adder cells.
// Combinational, no backpressure; c_msb is the carry entering the top bit.
module ripple_digit #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      full_adder u_fa (
         .x  (x[i]),
         .y  (y[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign cout  = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement add/sub, DIGIT bits per cycle with a registered carry.
// Latency: out_valid rises WIDTH/DIGIT cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
      $error("serial_add_sub: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)", WIDTH, DIGIT);
   end

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry;
   logic [DIGIT-1:0]  d_s;
   logic              d_co;
   logic              d_cmsb;
   logic [WIDTH-1:0]  sum_nxt;

   ripple_digit #(.DIGIT(DIGIT)) u_digit (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .cin   (carry),
      .s     (d_s),
      .cout  (d_co),
      .c_msb (d_cmsb)
   );

   // Digits enter from the MSB side so the sum lands aligned after N shifts.
   if (DIGIT == WIDTH) begin : g_one_digit
      assign sum_nxt = d_s;
   end else begin : g_multi_digit
      assign sum_nxt = {d_s, sum[WIDTH-1:DIGIT]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= sub ? ~b : b;
                  carry    <= sub;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               sum   <= sum_nxt;
               carry <= d_co;
               if (cnt == LAST) begin
                  cout      <= d_co;
                  ovf       <= d_cmsb ^ d_co;
                  zero      <= (sum_nxt == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed table and corner sequences at DIGIT=8,
// plus random sweeps at DIGIT 1, 4 and 32 against an arithmetic reference.
module tb_serial_add_sub;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst_sw;
   logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
   logic [31:0] a, b, sum;

   int errors = 0;
   int checks = 0;
   int sw_finished = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] s;
      logic        c;
      logic        o;
      logic        z;
   } vec_t;

   vec_t vecs[9];

   serial_add_sub #(.WIDTH(32), .DIGIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic; returns {sum, cout, ovf, zero}.
   function automatic logic [34:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic s);
      logic [31:0] r;
      logic        c, o;
      longint      sr;
      if (s) begin
         r  = x - y;
         c  = (x >= y);
         sr = longint'($signed(x)) - longint'($signed(y));
      end else begin
         r  = x + y;
         c  = (({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF);
         sr = longint'($signed(x)) + longint'($signed(y));
      end
      o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {r, c, o, (r == 32'd0)};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic ts,
                         output logic [31:0] rs, output logic rc, output logic ro,
                         output logic rz, output int lat);
      @(negedge clk);
      check("accept_ready", in_ready, 1);
      a = ta; b = tb2; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom(); b = $urandom(); sub = 1'($urandom_range(0, 1));
      wait_valid(lat);
      rs = sum; rc = cout; ro = ovf; rz = zero;
      in_valid = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      rst_sw = 1'b0;
      #23 rst_sw = 1'b1;
   end

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int D  = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
      localparam int NN = 32 / D;
      logic        iv, ir, ov, orr, c, o, z, s;
      logic [31:0] xa, xb, xs;

      serial_add_sub #(.WIDTH(32), .DIGIT(D)) u_dut (
         .clk       (clk),
         .rst       (rst_sw),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (xa),
         .b         (xb),
         .sub       (s),
         .out_valid (ov),
         .out_ready (orr),
         .sum       (xs),
         .cout      (c),
         .ovf       (o),
         .zero      (z)
      );

      initial begin
         logic [31:0] opa, opb;
         logic        ops;
         logic [34:0] e;
         int          lat;
         iv = 1'b0; orr = 1'b1; xa = '0; xb = '0; s = 1'b0;
         repeat (4) @(negedge clk);
         for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            check($sformatf("d%0d_ready", D), ir, 1);
            opa = pick(); opb = pick(); ops = 1'($urandom_range(0, 1));
            xa = opa; xb = opb; s = ops; iv = 1'b1;
            @(posedge clk); #1;
            iv = 1'($urandom_range(0, 1));
            xa = $urandom(); xb = $urandom(); s = 1'($urandom_range(0, 1));
            lat = 0;
            while (!ov && lat < 200) begin
               @(posedge clk); #1;
               lat++;
            end
            e = ref_op(opa, opb, ops);
            check($sformatf("d%0d_latency", D), lat, NN);
            check($sformatf("d%0d_sum", D), xs, e[34:3]);
            check($sformatf("d%0d_flags", D), {c, o, z}, e[2:0]);
            iv = 1'b0;
            @(posedge clk);
         end
         sw_finished++;
      end
   end

   initial begin
      logic [31:0] rs;
      logic        rc, ro, rz;
      int          lat;

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;

      vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};

      #12;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_sum", sum, 0);
      check("reset_flags", {cout, ovf, zero}, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro, rz, lat);
         check($sformatf("v%0d_latency", i), lat, 4);
         check($sformatf("v%0d_sum", i), rs, vecs[i].s);
         check($sformatf("v%0d_cout", i), rc, vecs[i].c);
         check($sformatf("v%0d_ovf", i), ro, vecs[i].o);
         check($sformatf("v%0d_zero", i), rz, vecs[i].z);
      end

      // Backpressure: result must hold while new operands are offered.
      @(negedge clk);
      a = 32'h0000_000A; b = 32'h0000_0014; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      check("bp_latency", lat, 4);
      in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d_valid", k), out_valid, 1);
         check($sformatf("bp_hold%0d_ready", k), in_ready, 0);
         check($sformatf("bp_hold%0d_sum", k), sum, 32'h0000_001E);
         check($sformatf("bp_hold%0d_flags", k), {cout, ovf, zero}, 3'b000);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      check("bp_next_accepted", in_ready, 0);
      in_valid = 1'b0;
      wait_valid(lat);
      check("bp_next_latency", lat, 4);
      check("bp_next_sum", sum, 32'h0000_0000);
      check("bp_next_flags", {cout, ovf, zero}, 3'b101);
      @(posedge clk);

      // Reset pulse during the second RUN cycle aborts the op.
      @(negedge clk);
      a = 32'hDEAD_BEEF; b = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_sum", sum, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_no_valid", out_valid, 0);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, rs, rc, ro, rz, lat);
      check("post_rst_latency", lat, 4);
      check("post_rst_sum", rs, 32'h2345_6789);
      check("post_rst_flags", {rc, ro, rz}, 3'b000);

      for (int t = 0; t < 60000 && sw_finished < 3; t++) @(posedge clk);
      check("sweeps_done", sw_finished, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
